grid_step_sequencer: RTL and testbench



---
 rtl/snake_grid_pkg.sv | 32 +++
 rtl/grid_step_sequencer_step_timer.sv | 42 ++++
 rtl/grid_step_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_grid_step_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_grid_pkg.sv
// Shared types for the two-snake play field: grid cell codes and the step sequencer states.
package snake_grid_pkg;

  localparam int GRID_W_DEF = 64;
  localparam int GRID_H_DEF = 48;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_S1    = 2'b01,
    CELL_S2    = 2'b10,
    CELL_WALL  = 2'b11
  } cell_t;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLEAR     = 4'd1,
    WAIT_STEP = 4'd2,
    RD_S1     = 4'd3,
    RD_S2     = 4'd4,
    CHK       = 4'd5,
    WR_S1     = 4'd6,
    WR_S2     = 4'd7,
    ADV       = 4'd8,
    DONE      = 4'd9
  } seq_state_t;

  // Any non-empty code (either snake or a wall) blocks a head from entering the cell.
  function automatic logic cell_blocked(input logic [1:0] code);
    return code != CELL_EMPTY;
  endfunction

endpackage

// File: rtl/grid_step_sequencer_step_timer.sv
// Counts unpaused frame ticks while enabled and flags the tick that completes a game step.
module step_timer #(
  parameter int STEP_FRAMES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_pause,
  input  logic i_frame_tick,
  output logic o_step_due
);

  localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick     = i_en && i_frame_tick && !i_pause;
  assign o_step_due = w_tick && (r_cnt == CNT_LAST);

  // Frame counter: held while paused or disabled, wraps to zero on the qualifying tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (w_tick) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/grid_step_sequencer.sv
// Play-field step sequencer: clears the occupancy grid, then every STEP_FRAMES frames
// reads both proposed head cells, decides the outcome and marks the heads or ends the game.
module grid_step_sequencer
  import snake_grid_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int X_W         = 6,
  parameter int Y_W         = 6,
  parameter int ADDR_W      = 12,
  parameter int STEP_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run_en,
  input  logic              pause,
  input  logic              frame_tick,
  input  logic [X_W-1:0]    s1_next_x,
  input  logic [Y_W-1:0]    s1_next_y,
  input  logic [X_W-1:0]    s2_next_x,
  input  logic [Y_W-1:0]    s2_next_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic              s1_advance,
  output logic              s2_advance,
  output logic              player1wins,
  output logic              player2wins,
  output logic              tie,
  output logic              clear_busy,
  output logic [15:0]       step_count
);

  localparam logic [31:0]       GRID_W_U  = 32'(GRID_W);
  localparam logic [31:0]       GRID_H_U  = 32'(GRID_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [1:0]        r_mem_wdata;
  logic              r_s1_adv;
  logic              r_s2_adv;
  logic              r_p1_wins;
  logic              r_p2_wins;
  logic              r_tie;
  logic              r_clear_busy;
  logic [15:0]       r_step_count;
  logic [X_W-1:0]    r_s1_x;
  logic [Y_W-1:0]    r_s1_y;
  logic [X_W-1:0]    r_s2_x;
  logic [Y_W-1:0]    r_s2_y;
  logic [1:0]        r_s1_cell;

  logic w_step_due;
  logic w_timer_en;
  logic w_timer_clr;
  logic w_same_head;
  logic w_s1_hit;
  logic w_s2_hit;

  // Linear cell address; out-of-range heads simply alias somewhere in the RAM.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic [31:0] lin;
    lin = 32'(y) * GRID_W_U + 32'(x);
    return lin[ADDR_W-1:0];
  endfunction

  function automatic logic off_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) >= GRID_W_U) || (32'(y) >= GRID_H_U);
  endfunction

  assign w_timer_en  = run_en && (r_state == WAIT_STEP);
  assign w_timer_clr = (r_state == IDLE);
  assign w_same_head = (r_s1_x == r_s2_x) && (r_s1_y == r_s2_y);
  // s2's cell arrives on mem_rdata during CHK; s1's was captured one cycle earlier.
  assign w_s1_hit    = cell_blocked(r_s1_cell) || off_grid(r_s1_x, r_s1_y);
  assign w_s2_hit    = cell_blocked(mem_rdata) || off_grid(r_s2_x, r_s2_y);

  step_timer #(
    .STEP_FRAMES (STEP_FRAMES)
  ) u_step_timer (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_en         (w_timer_en),
    .i_clr        (w_timer_clr),
    .i_pause      (pause),
    .i_frame_tick (frame_tick),
    .o_step_due   (w_step_due)
  );

  // Sequencer FSM with all outputs registered; run_en low overrides every state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_mem_addr   <= ADDR_ZERO;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= CELL_EMPTY;
      r_s1_adv     <= 1'b0;
      r_s2_adv     <= 1'b0;
      r_p1_wins    <= 1'b0;
      r_p2_wins    <= 1'b0;
      r_tie        <= 1'b0;
      r_clear_busy <= 1'b0;
      r_step_count <= 16'd0;
      r_s1_x       <= {X_W{1'b0}};
      r_s1_y       <= {Y_W{1'b0}};
      r_s2_x       <= {X_W{1'b0}};
      r_s2_y       <= {Y_W{1'b0}};
      r_s1_cell    <= CELL_EMPTY;
    end else if (!run_en) begin
      r_state      <= IDLE;
      r_mem_addr   <= ADDR_ZERO;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= CELL_EMPTY;
      r_s1_adv     <= 1'b0;
      r_s2_adv     <= 1'b0;
      r_p1_wins    <= 1'b0;
      r_p2_wins    <= 1'b0;
      r_tie        <= 1'b0;
      r_clear_busy <= 1'b0;
      r_step_count <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state      <= CLEAR;
          r_mem_addr   <= ADDR_ZERO;
          r_mem_we     <= 1'b1;
          r_mem_wdata  <= CELL_EMPTY;
          r_clear_busy <= 1'b1;
          r_step_count <= 16'd0;
        end
        CLEAR: begin
          if (r_mem_addr == LAST_ADDR) begin
            r_state      <= WAIT_STEP;
            r_mem_addr   <= ADDR_ZERO;
            r_mem_we     <= 1'b0;
            r_clear_busy <= 1'b0;
          end else begin
            r_mem_addr   <= r_mem_addr + ADDR_ONE;
            r_mem_we     <= 1'b1;
            r_clear_busy <= 1'b1;
          end
        end
        WAIT_STEP: begin
          r_mem_we <= 1'b0;
          r_s1_adv <= 1'b0;
          r_s2_adv <= 1'b0;
          if (w_step_due) begin
            r_state    <= RD_S1;
            r_s1_x     <= s1_next_x;
            r_s1_y     <= s1_next_y;
            r_s2_x     <= s2_next_x;
            r_s2_y     <= s2_next_y;
            r_mem_addr <= cell_addr(s1_next_x, s1_next_y);
          end else begin
            r_state <= WAIT_STEP;
          end
        end
        RD_S1: begin
          r_state    <= RD_S2;
          r_mem_addr <= cell_addr(r_s2_x, r_s2_y);
        end
        RD_S2: begin
          r_state   <= CHK;
          r_s1_cell <= mem_rdata;
        end
        CHK: begin
          if (w_same_head || (w_s1_hit && w_s2_hit)) begin
            r_state  <= DONE;
            r_tie    <= 1'b1;
            r_mem_we <= 1'b0;
          end else if (w_s1_hit) begin
            r_state   <= DONE;
            r_p2_wins <= 1'b1;
            r_mem_we  <= 1'b0;
          end else if (w_s2_hit) begin
            r_state   <= DONE;
            r_p1_wins <= 1'b1;
            r_mem_we  <= 1'b0;
          end else begin
            r_state     <= WR_S1;
            r_mem_addr  <= cell_addr(r_s1_x, r_s1_y);
            r_mem_we    <= 1'b1;
            r_mem_wdata <= CELL_S1;
          end
        end
        WR_S1: begin
          r_state     <= WR_S2;
          r_mem_addr  <= cell_addr(r_s2_x, r_s2_y);
          r_mem_we    <= 1'b1;
          r_mem_wdata <= CELL_S2;
        end
        WR_S2: begin
          r_state     <= ADV;
          r_mem_we    <= 1'b0;
          r_mem_wdata <= CELL_EMPTY;
          r_s1_adv    <= 1'b1;
          r_s2_adv    <= 1'b1;
        end
        ADV: begin
          r_state      <= WAIT_STEP;
          r_s1_adv     <= 1'b0;
          r_s2_adv     <= 1'b0;
          r_step_count <= r_step_count + 16'd1;
        end
        DONE: begin
          r_state  <= DONE;
          r_mem_we <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_mem_we     <= 1'b0;
          r_clear_busy <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign s1_advance  = r_s1_adv;
  assign s2_advance  = r_s2_adv;
  assign player1wins = r_p1_wins;
  assign player2wins = r_p2_wins;
  assign tie         = r_tie;
  assign clear_busy  = r_clear_busy;
  assign step_count  = r_step_count;

endmodule

// File: tb/tb_grid_step_sequencer.sv
// Randomized bench: a grid-level model predicts each step's writes, advances and outcome.
module tb_grid_step_sequencer;

  localparam int GW = 64;
  localparam int GH = 48;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        run_en = 1'b0;
  logic        pause = 1'b0;
  logic        frame_tick = 1'b0;
  logic [5:0]  s1_next_x = 6'd0;
  logic [5:0]  s1_next_y = 6'd0;
  logic [5:0]  s2_next_x = 6'd0;
  logic [5:0]  s2_next_y = 6'd0;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;
  logic        s1_advance, s2_advance, player1wins, player2wins, tie, clear_busy;
  logic [15:0] step_count;

  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = 12'd0;
  logic [1:0]  poke_data = 2'b00;
  logic [1:0]  mem [0:4095];
  logic [1:0]  ref_grid [0:GW*GH-1];

  int checks = 0;
  int errors = 0;
  int stray = 0;
  int model_steps = 0;

  grid_step_sequencer dut (
    .Clk(Clk), .Reset(Reset), .run_en(run_en), .pause(pause), .frame_tick(frame_tick),
    .s1_next_x(s1_next_x), .s1_next_y(s1_next_y), .s2_next_x(s2_next_x), .s2_next_y(s2_next_y),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .s1_advance(s1_advance), .s2_advance(s2_advance), .player1wins(player1wins),
    .player2wins(player2wins), .tie(tie), .clear_busy(clear_busy), .step_count(step_count)
  );

  always #5 Clk = ~Clk;

  // Single-port grid RAM with one-cycle read latency; the bench can also poke cells.
  always @(posedge Clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] out_bits();
    return {mem_we, s1_advance, s2_advance, player1wins, player2wins, tie, clear_busy};
  endfunction

  // Outcome as {player1wins, player2wins, tie} from the game rules applied to the model grid.
  function automatic logic [2:0] predict(input int x1, input int y1, input int x2, input int y2);
    bit hit1, hit2;
    hit1 = ((x1 < GW) && (y1 < GH)) ? (ref_grid[y1*GW + x1] != 2'b00) : 1'b1;
    hit2 = ((x2 < GW) && (y2 < GH)) ? (ref_grid[y2*GW + x2] != 2'b00) : 1'b1;
    if ((x1 == x2 && y1 == y2) || (hit1 && hit2)) return 3'b001;
    else if (hit1) return 3'b010;
    else if (hit2) return 3'b100;
    else return 3'b000;
  endfunction

  task automatic poke(input int x, input int y, input logic [1:0] d);
    ref_grid[y*GW + x] = d;
    poke_en = 1'b1; poke_addr = 12'(y*GW + x); poke_data = d;
    @(posedge Clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic note_idle();
    if (mem_we || s1_advance || s2_advance) stray++;
  endtask

  task automatic tick(input logic paused);
    int gap;
    pause = paused; frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0; pause = 1'b0;
    note_idle();
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      @(posedge Clk); #1;
      note_idle();
    end
  endtask

  task automatic start_game();
    int cnt, seqerr, nz;
    run_en = 1'b0;
    @(posedge Clk); #1;
    check_val("idle_outputs", 32'(out_bits()), 32'd0);
    check_val("idle_steps", 32'(step_count), 32'd0);
    run_en = 1'b1;
    cnt = 0; seqerr = 0;
    @(posedge Clk); #1;
    while (clear_busy && cnt < 4000) begin
      if (!mem_we || mem_wdata != 2'b00 || mem_addr != 12'(cnt)) seqerr++;
      cnt++;
      @(posedge Clk); #1;
    end
    check_val("clear_cycles", cnt, GW*GH);
    check_val("clear_sequence", seqerr, 0);
    check_val("clear_we_after", 32'(mem_we), 32'd0);
    nz = 0;
    for (int i = 0; i < GW*GH; i++) if (mem[i] !== 2'b00) nz++;
    check_val("clear_content", nz, 0);
    for (int i = 0; i < GW*GH; i++) ref_grid[i] = 2'b00;
    model_steps = 0;
  endtask

  task automatic do_step(input int x1, input int y1, input int x2, input int y2,
                         input int npause, output bit over);
    logic [2:0] exp_f, fl;
    int nw, w1, w2, adv1n, adv1j, adv2n, adv2j, fj, sc;
    exp_f = predict(x1, y1, x2, y2);
    s1_next_x = 6'(x1); s1_next_y = 6'(y1);
    s2_next_x = 6'(x2); s2_next_y = 6'(y2);
    stray = 0;
    tick(1'b0);
    for (int p = 0; p < npause; p++) tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    pause = 1'b0; frame_tick = 1'b1;
    nw = 0; w1 = 0; w2 = 0; adv1n = 0; adv1j = 0; adv2n = 0; adv2j = 0; fj = 0; fl = 3'b000; sc = 0;
    for (int j = 1; j <= 9; j++) begin
      @(posedge Clk); #1;
      if (mem_we) begin
        nw++;
        if (nw == 1) w1 = j*65536 + int'(mem_addr)*4 + int'(mem_wdata);
        else if (nw == 2) w2 = j*65536 + int'(mem_addr)*4 + int'(mem_wdata);
      end
      if (s1_advance) begin adv1n++; adv1j = j; end
      if (s2_advance) begin adv2n++; adv2j = j; end
      if (fj == 0 && {player1wins, player2wins, tie} != 3'b000) fj = j;
      if (j == 9) begin fl = {player1wins, player2wins, tie}; sc = int'(step_count); end
      case (j)
        1: frame_tick = 1'b0;
        2: begin
          pause = 1'($urandom_range(0, 1));
          s1_next_x = 6'($urandom); s1_next_y = 6'($urandom);
          s2_next_x = 6'($urandom); s2_next_y = 6'($urandom);
        end
        3: frame_tick = 1'b1;
        4: frame_tick = 1'b0;
        default: ;
      endcase
    end
    pause = 1'b0;
    check_val("stray_activity", stray, 0);
    if (exp_f == 3'b000) begin
      model_steps++;
      ref_grid[y1*GW + x1] = 2'b01;
      ref_grid[y2*GW + x2] = 2'b10;
      check_val("write_count", nw, 2);
      check_val("write_s1", w1, 4*65536 + (y1*GW + x1)*4 + 1);
      check_val("write_s2", w2, 5*65536 + (y2*GW + x2)*4 + 2);
      check_val("advance_s1", adv1n*16 + adv1j, 16 + 6);
      check_val("advance_s2", adv2n*16 + adv2j, 16 + 6);
      check_val("flag_time", fj, 0);
    end else begin
      check_val("write_count", nw, 0);
      check_val("advance_none", adv1n + adv2n, 0);
      check_val("flag_time", fj, 4);
    end
    check_val("flags", 32'(fl), 32'(exp_f));
    check_val("step_count", sc, model_steps);
    over = (exp_f != 3'b000);
  endtask

  initial begin
    bit over;
    int x1, y1, x2, y2, nwall;

    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_outputs", 32'(out_bits()), 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_val("rst_idle_outputs", 32'(out_bits()), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_steps", 32'(step_count), 32'd0);

    // Stale cells that the first clear must wipe.
    poke(0, 0, 2'b11);
    poke(63, 47, 2'b10);
    poke(17, 20, 2'b01);

    // Abandon a clear part way through.
    run_en = 1'b1;
    repeat (100) begin @(posedge Clk); #1; end
    check_val("mid_clear_busy", 32'(clear_busy), 32'd1);
    check_val("mid_clear_addr", 32'(mem_addr), 32'd99);
    run_en = 1'b0;
    @(posedge Clk); #1;
    check_val("abort_we_busy", 32'({mem_we, clear_busy}), 32'd0);

    start_game();
    do_step(10, 5, 50, 40, 0, over);
    do_step(11, 5, 51, 40, 10, over);
    poke(12, 5, 2'b10);
    do_step(12, 5, 52, 40, 0, over);

    start_game();
    do_step(20, 20, 20, 20, 0, over);

    start_game();
    poke(3, 3, 2'b11);
    poke(4, 4, 2'b11);
    do_step(3, 3, 4, 4, 0, over);

    start_game();
    do_step(5, 5, 63, 50, 1, over);

    for (int g = 0; g < 10; g++) begin
      start_game();
      nwall = $urandom_range(0, 4);
      for (int w = 0; w < nwall; w++) poke($urandom_range(0, 7), $urandom_range(0, 7), 2'b11);
      over = 1'b0;
      for (int s = 0; s < 8 && !over; s++) begin
        x1 = $urandom_range(0, 7);
        y1 = ($urandom_range(0, 9) == 0) ? $urandom_range(48, 63) : $urandom_range(0, 7);
        x2 = $urandom_range(0, 7);
        y2 = ($urandom_range(0, 9) == 0) ? $urandom_range(48, 63) : $urandom_range(0, 7);
        if ($urandom_range(0, 9) == 0) begin x2 = x1; y2 = y1; end
        do_step(x1, y1, x2, y2, $urandom_range(0, 2), over);
      end
    end

    run_en = 1'b0;
    @(posedge Clk); #1;
    check_val("final_idle_outputs", 32'(out_bits()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
